// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared pipeline constants and the fetch-state encoding
package if_fetch_stage_pkg;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_next_pc.sv
// if_next_pc: combinational next-PC mux and misaligned-redirect detect
//   pc, boot, stall, redirect, redirect_pc in; next_pc, misalign out
module if_next_pc (
   input  logic        boot,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        misalign
);
   assign next_pc  = redirect ? {redirect_pc[31:2], 2'b00} : (boot || stall) ? pc : pc + 32'd4;
   assign misalign = redirect && |redirect_pc[1:0];
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: miniRV fetch stage owning the PC, fetch FSM, fetch counter and misalign flag
//   cpu_clk, cpu_rst_n (async, active-low), stall, redirect, redirect_pc in
//   irom_addr out, irom_inst in
//   pc_IF_out, pc4_IF_out, inst_IF_out, inst_valid_IF_out out to IF/ID
//   fetch_cnt, misalign_err debug out
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          IROM_AW  = 14
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst_n,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic [IROM_AW-1:0] irom_addr,
   input  logic [31:0]        irom_inst,
   output logic [31:0]        pc_IF_out,
   output logic [31:0]        pc4_IF_out,
   output logic [31:0]        inst_IF_out,
   output logic               inst_valid_IF_out,
   output logic [31:0]        fetch_cnt,
   output logic               misalign_err
);
   fetch_state_t state, state_nxt;
   logic [31:0]  pc_nxt;
   logic         misalign;
   if_next_pc u_next_pc (
      .boot        (state == BOOT),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc_IF_out),
      .next_pc     (pc_nxt),
      .misalign    (misalign)
   );
   assign irom_addr  = pc_IF_out[IROM_AW+1:2];
   assign pc4_IF_out = pc_IF_out + 32'd4;
   // a redirect pulls the whole pipe back to RUN, even out of a stall
   always_comb begin
      state_nxt         = (state != BOOT && stall && !redirect) ? STALL : RUN;
      inst_valid_IF_out = (state != BOOT) && !redirect;
      inst_IF_out       = inst_valid_IF_out ? irom_inst : NOP_INST;
   end
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state        <= BOOT;
         pc_IF_out    <= RESET_PC;
         fetch_cnt    <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc_IF_out    <= pc_nxt;
         fetch_cnt    <= fetch_cnt + {31'd0, inst_valid_IF_out && !stall};
         misalign_err <= misalign_err | misalign;
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage with directed vectors
`timescale 1ns/1ps
module tb_if_fetch_stage;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        v;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;
   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [13:0] irom_addr;
   logic [31:0] irom_inst;
   logic [31:0] pc_IF_out, pc4_IF_out, inst_IF_out, fetch_cnt;
   logic        inst_valid_IF_out, misalign_err;
   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   if_fetch_stage dut (
      .cpu_clk           (cpu_clk),
      .cpu_rst_n         (cpu_rst_n),
      .stall             (stall),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .irom_addr         (irom_addr),
      .irom_inst         (irom_inst),
      .pc_IF_out         (pc_IF_out),
      .pc4_IF_out        (pc4_IF_out),
      .inst_IF_out       (inst_IF_out),
      .inst_valid_IF_out (inst_valid_IF_out),
      .fetch_cnt         (fetch_cnt),
      .misalign_err      (misalign_err)
   );
   always #5 cpu_clk = ~cpu_clk;
   assign irom_inst = 32'h1000_0000 + {18'd0, irom_addr};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, " pc"}, pc_IF_out, e.pc);
      chk({tag, " pc4"}, pc4_IF_out, e.pc4);
      chk({tag, " inst"}, inst_IF_out, e.inst);
      chk({tag, " valid"}, {31'd0, inst_valid_IF_out}, {31'd0, e.v});
      chk({tag, " cnt"}, fetch_cnt, e.cnt);
      chk({tag, " mis"}, {31'd0, misalign_err}, {31'd0, e.mis});
   endtask
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] pc, input logic [31:0] pc4, input logic v,
                       input logic [31:0] inst, input logic [31:0] cnt, input logic mis);
      exp_t e;
      @(posedge cpu_clk);
      #1;
      stall = st;
      redirect = rd;
      redirect_pc = rpc;
      e.pc = pc; e.pc4 = pc4; e.inst = inst; e.v = v; e.cnt = cnt; e.mis = mis;
      sb.push_back(e);
   endtask
   always @(negedge cpu_clk) begin
      if (sb.size() != 0) chk_all("row", sb.pop_front());
   end
   initial begin
      exp_t e;
      #1;
      e.pc = 32'h0; e.pc4 = 32'h4; e.inst = 32'h13; e.v = 1'b0; e.cnt = 32'd0; e.mis = 1'b0;
      chk_all("reset", e);
      #1 cpu_rst_n = 1'b1;
      #1 chk_all("boot", e);
      step(0, 0, 32'h0,   32'h00, 32'h04, 1, 32'h1000_0000, 0, 0);
      step(0, 0, 32'h0,   32'h04, 32'h08, 1, 32'h1000_0001, 1, 0);
      step(0, 0, 32'h0,   32'h08, 32'h0C, 1, 32'h1000_0002, 2, 0);
      step(0, 0, 32'h0,   32'h0C, 32'h10, 1, 32'h1000_0003, 3, 0);
      step(1, 0, 32'h0,   32'h10, 32'h14, 1, 32'h1000_0004, 4, 0);
      step(1, 0, 32'h0,   32'h10, 32'h14, 1, 32'h1000_0004, 4, 0);
      step(1, 0, 32'h0,   32'h10, 32'h14, 1, 32'h1000_0004, 4, 0);
      step(0, 0, 32'h0,   32'h10, 32'h14, 1, 32'h1000_0004, 4, 0);
      step(0, 0, 32'h0,   32'h14, 32'h18, 1, 32'h1000_0005, 5, 0);
      step(0, 0, 32'h0,   32'h18, 32'h1C, 1, 32'h1000_0006, 6, 0);
      step(0, 0, 32'h0,   32'h1C, 32'h20, 1, 32'h1000_0007, 7, 0);
      step(0, 1, 32'h100, 32'h20, 32'h24, 0, 32'h13,        8, 0);
      step(0, 0, 32'h0,   32'h100, 32'h104, 1, 32'h1000_0040, 8, 0);
      step(1, 1, 32'h80,  32'h104, 32'h108, 0, 32'h13,        9, 0);
      step(0, 0, 32'h0,   32'h80, 32'h84, 1, 32'h1000_0020, 9, 0);
      step(0, 1, 32'h102, 32'h84, 32'h88, 0, 32'h13,        10, 0);
      step(0, 0, 32'h0,   32'h100, 32'h104, 1, 32'h1000_0040, 10, 1);
      for (int i = 0; i < 10; i++)
         step(0, 0, 32'h0, 32'h104 + 4 * i, 32'h108 + 4 * i, 1, 32'h1000_0041 + i, 11 + i, 1);
      step(0, 1, 32'hFFFF_FFFC, 32'h12C, 32'h130, 0, 32'h13, 21, 1);
      step(0, 0, 32'h0,   32'hFFFF_FFFC, 32'h0, 1, 32'h1000_3FFF, 21, 1);
      step(0, 0, 32'h0,   32'h00, 32'h04, 1, 32'h1000_0000, 22, 1);
      step(1, 0, 32'h0,   32'h04, 32'h08, 1, 32'h1000_0001, 23, 1);
      step(1, 0, 32'h0,   32'h04, 32'h08, 1, 32'h1000_0001, 23, 1);
      @(negedge cpu_clk);
      #1 cpu_rst_n = 1'b0;
      #1 chk_all("midreset", e);
      stall = 1'b0;
      #1 cpu_rst_n = 1'b1;
      #1 chk_all("boot2", e);
      step(0, 0, 32'h0,   32'h00, 32'h04, 1, 32'h1000_0000, 0, 0);
      step(0, 0, 32'h0,   32'h04, 32'h08, 1, 32'h1000_0001, 1, 0);
      for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge cpu_clk);
      #1;
      chk("drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the miniRV pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter, next-PC selection (sequential, stall hold, EX-stage redirect) and the instruction-ROM address. It presents `pc`, `pc+4`, instruction and a valid flag to IF/ID, and keeps a fetch counter and a misalignment flag for debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `IROM_AW`, default 14: IROM word-address width.

Ports:
- `cpu_clk`  in  1  pipeline clock.
- `cpu_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `stall`  in  1  hazard-unit hold. The same signal drives the IF/ID hold.
- `redirect`  in  1  taken branch or jump from EX.
- `redirect_pc`  in  32  branch or jump target.
- `irom_addr`  out  IROM_AW  `pc[IROM_AW+1:2]`, combinational from the PC register.
- `irom_inst`  in  32  combinational IROM read data.
- `pc_IF_out`  out  32  current PC (register).
- `pc4_IF_out`  out  32  `pc_IF_out + 4`, mod 2^32.
- `inst_IF_out`  out  32  `irom_inst` when valid, else NOP 32'h0000_0013.
- `inst_valid_IF_out`  out  1  fetched instruction is on the correct path.
- `fetch_cnt`  out  32  count of instructions accepted by IF/ID.
- `misalign_err`  out  1  sticky: a redirect target had bits [1:0] not equal to 0.

## Operation
- States: BOOT, RUN, STALL.
  - BOOT is entered on reset and lasts exactly one cycle.
  - In BOOT, `inst_valid_IF_out` = 0 and the PC holds `RESET_PC`.
- State transitions (evaluated at each edge):
  - BOOT → RUN always, whether or not `redirect` is high.
  - RUN → STALL if `stall` is high and `redirect` is low; otherwise stay in RUN.
  - STALL → RUN if `stall` is low or `redirect` is high.
- Next-PC selection, in priority order:
  1. `redirect`: PC ← `{redirect_pc[31:2], 2'b00}`.
  2. BOOT or `stall`: PC ← PC (hold).
  3. Otherwise: PC ← PC + 4.
- Redirect handling:
  - `redirect` wins over `stall`, because the stalled instruction is on the wrong path.
  - If `redirect_pc[1:0]` ≠ 0, `misalign_err` is set and stays set until reset.
- Valid and instruction output:
  - `inst_valid_IF_out` = (state ≠ BOOT) && !`redirect`.
  - When `inst_valid_IF_out` is low, `inst_IF_out` is forced to NOP.
- Fetch counter:
  - `fetch_cnt` increments when `inst_valid_IF_out` is high and `stall` is low.
  - It wraps from 0xFFFF_FFFF to 0.
- PC arithmetic is 32-bit unsigned and wraps: PC = 0xFFFF_FFFC gives `pc4_IF_out` = 0.
- Reset values:
  - PC = `RESET_PC`; `pc4_IF_out` = `RESET_PC` + 4.
  - `inst_valid_IF_out` = 0; `inst_IF_out` = NOP.
  - `fetch_cnt` = 0; `misalign_err` = 0; state = BOOT.

## Timing
- Instruction data is combinational from `irom_inst` in the same cycle the PC is presented.
- IF/ID captures the fetched instruction at the next edge.
- Redirect:
  - Sampled at edge N.
  - Cycle N+1: PC = target and `inst_valid_IF_out` = 1.
  - The cycle in which `redirect` is high outputs a NOP bubble.
- Stall:
  - PC, `pc4_IF_out` and `inst_IF_out` stay stable for every cycle `stall` is high.
  - On the first edge after `stall` drops, PC advances.
- Reset mid-operation: asserting `cpu_rst_n` low immediately forces all reset values. This applies in any state, including STALL and a pending redirect.
- After release, the first valid fetch of `RESET_PC` appears one cycle later, after BOOT.

## Structure
- Shared pipeline package holds:
  - `NOP_INST` = 32'h0000_0013.
  - The fetch-state encoding (BOOT, RUN, STALL; 2 bits).
  - The `RESET_PC` default.
- One sub-module, `if_next_pc`: combinational next-PC mux plus misalignment detect.
- The top level holds the PC register, FSM, counter and sticky flag.

## Test plan
- Reset release, IROM word k = 0x1000_0000 + k:
  - Cycle 1: PC = 0, valid = 0, inst = 0x13.
  - Cycle 2: PC = 0, valid = 1, inst = 0x1000_0000.
  - Cycle 3: PC = 4.
- Stall for 3 cycles at PC = 0x10:
  - PC and inst hold at 0x10 and 0x1000_0004; `fetch_cnt` is frozen.
  - The cycle after stall drops: PC = 0x14.
- Redirect to 0x100 at PC = 0x20:
  - That cycle: valid = 0, inst = 0x13.
  - Next cycle: PC = 0x100, valid = 1, inst = 0x1000_0040.
- `redirect` and `stall` high together, target 0x80 → next PC = 0x80, state = RUN.
- Misaligned redirect to 0x102:
  - PC = 0x100 and `misalign_err` = 1.
  - `misalign_err` stays 1 through 10 further cycles; only reset clears it.
- Redirect to 0xFFFF_FFFC:
  - `pc4_IF_out` = 0; next PC = 0.
- Assert `cpu_rst_n` low mid-stall:
  - PC, `fetch_cnt` and `misalign_err` clear immediately, without waiting for a clock edge.
